// File: rtl/dm_byte_ctrl.sv
// dm_byte_ctrl: byte-addressable data-memory controller with a single
// outstanding request, little-endian lane handling and load extension.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   req_valid/ready request handshake (ready only while idle)
//   req_we          1 = store, 0 = load
//   req_addr        byte address (ADDR_W bits)
//   req_size        00 byte, 01 half, 10 word, 11 illegal
//   req_signed      load sign-extension select
//   req_wdata       right-aligned store data
//   rsp_valid       one-cycle response pulse
//   rsp_rdata       extended load data (0 for stores/errors)
//   rsp_err         misaligned / illegal-size flag, qualified by rsp_valid
module dm_byte_ctrl #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int WORDS = 1 << (ADDR_W - 2);
  // WAIT spans RD_LAT-1 cycles; the counter starts at RD_LAT-2 and exits on zero.
  localparam logic [1:0] CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [WORDS];

  logic              accept;
  logic              req_err;
  logic [ADDR_W-3:0] word_idx;
  logic [1:0]        lane;
  logic [3:0]        lane_we;
  logic [31:0]       wdata_lanes;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       ld_data;

  assign req_ready = (state_q == IDLE);
  // A request seen while reset is asserted must neither commit nor respond.
  assign accept    = req_valid & req_ready & rst_n;
  assign word_idx  = req_addr[ADDR_W-1:2];
  assign lane      = req_addr[1:0];

  always_comb begin
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = lane[0];
      2'b10:   req_err = |lane;
      default: req_err = 1'b1;
    endcase
  end

  // Store data is replicated across all lanes so only the enables depend on
  // the address; no data shifter is needed on the write path.
  always_comb begin
    lane_we     = '0;
    wdata_lanes = '0;
    case (req_size)
      2'b00: begin
        lane_we     = 4'b0001 << lane;
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_we     = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_we     = 4'b1111;
        wdata_lanes = req_wdata;
      end
    endcase
    if (!(accept && req_we && !req_err)) begin
      lane_we = '0;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (lane_we[k]) begin
        mem[word_idx][8*k +: 8] <= wdata_lanes[8*k +: 8];
      end
    end
  end

  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    case (req_size)
      2'b00:   ld_data = {{24{req_signed & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_data = {{16{req_signed & rd_shift[15]}}, rd_shift[15:0]};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d   = req_err;
          rdata_d = (req_we || req_err) ? '0 : ld_data;
          if (!req_we && !req_err && (RD_LAT > 1)) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_dm_byte_ctrl.sv
`timescale 1ns/1ps
module tb_dm_byte_ctrl;

  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]          rst_n, req_valid, req_we, req_signed;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][1:0]     req_size;
  logic [1:0][31:0]    req_wdata;
  logic                rdy0, rdy1, vld0, vld1, err0, err1;
  logic [31:0]         rd0, rd1;

  dm_byte_ctrl #(.ADDR_W(AW), .RD_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(rdy0),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
    .req_signed(req_signed[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(vld0), .rsp_rdata(rd0), .rsp_err(err0));

  dm_byte_ctrl #(.ADDR_W(AW), .RD_LAT(3)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(rdy1),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
    .req_signed(req_signed[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(vld1), .rsp_rdata(rd1), .rsp_err(err1));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] bmem [2][4096];
  int tests = 0;
  int fails = 0;

  function automatic int lat_of(int unsigned d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic ready_of(int unsigned d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction

  function automatic int q_size(int unsigned d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic q_push(int unsigned d, exp_t x);
    if (d == 0) q0.push_back(x); else q1.push_back(x);
  endtask

  task automatic q_pop(int unsigned d, output exp_t x);
    if (d == 0) x = q0.pop_front(); else x = q1.pop_front();
  endtask

  task automatic q_drop_last(int unsigned d);
    exp_t x;
    if (d == 0) x = q0.pop_back(); else x = q1.pop_back();
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  task automatic mon(int unsigned d, logic v, logic [31:0] rd, logic e);
    exp_t x;
    if (v !== 1'b1) begin
      check($sformatf("idle_valid%0d", d), {31'b0, v}, 32'd0);
      check($sformatf("idle_rdata%0d", d), rd, 32'd0);
      check($sformatf("idle_err%0d", d), {31'b0, e}, 32'd0);
    end else if (q_size(d) == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_rsp%0d: got rsp_valid=1 rdata=0x%08h, expected no response", d, rd);
    end else begin
      q_pop(d, x);
      check($sformatf("rsp_rdata%0d", d), rd, x.rdata);
      check($sformatf("rsp_err%0d", d), {31'b0, e}, {31'b0, x.err});
      check($sformatf("rsp_cycle%0d", d), cyc, x.cyc);
    end
  endtask

  always @(negedge clk) mon(0, vld0, rd0, err0);
  always @(negedge clk) mon(1, vld1, rd1, err1);

  function automatic logic is_err(logic [1:0] sz, logic [AW-1:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  // Called right after a negedge; returns right after the negedge that
  // follows the accept edge, leaving req_valid asserted.
  task automatic issue(int unsigned d, logic we, logic [AW-1:0] a, logic [1:0] sz,
                       logic sg, logic [31:0] wd, int exp_wait, output int busy);
    int n;
    int nb;
    logic e;
    logic [31:0] v;
    exp_t x;
    n = 0;
    busy = 0;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a;
    req_size[d] = sz; req_signed[d] = sg; req_wdata[d] = wd;
    while (ready_of(d) !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 20) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout%0d: got no req_ready in %0d cycles, expected within 20", d, n);
        req_valid[d] = 1'b0;
        return;
      end
    end
    if (exp_wait >= 0) check($sformatf("ready_low_cycles%0d", d), 32'(n), 32'(exp_wait));
    e  = is_err(sz, a);
    nb = 1 << sz;
    v  = '0;
    if (!e && we) begin
      for (int unsigned i = 0; i < nb; i++) bmem[d][a + i] = wd[8*i +: 8];
    end else if (!e) begin
      for (int unsigned i = 0; i < nb; i++) v = v + (32'(bmem[d][a + i]) << (8 * i));
      if (sg && nb == 1 && v >= 128)   v = v - 32'd256;
      if (sg && nb == 2 && v >= 32768) v = v - 32'd65536;
    end
    busy    = (!we && !e) ? lat_of(d) : 1;
    x.rdata = v;
    x.err   = e;
    x.cyc   = cyc + busy;
    q_push(d, x);
    @(negedge clk);
  endtask

  task automatic idle(int unsigned d, int k);
    req_valid[d] = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic run_instance(int unsigned d);
    int busy;
    int ew;
    logic we, sg;
    logic [1:0] sz;
    logic [AW-1:0] a;

    // Fill every word so no load ever reads uninitialised memory.
    ew = -1;
    for (int unsigned w = 0; w < 1024; w++) begin
      issue(d, 1'b1, AW'(w * 4), 2'd2, 1'b0, $urandom(), ew, busy);
      ew = busy;
    end
    idle(d, 3);

    // Directed sequence around word 0x010.
    issue(d, 1, 12'h010, 2, 0, 32'h11223344, -1, busy);
    issue(d, 0, 12'h010, 2, 0, 32'h0, busy, busy);
    issue(d, 1, 12'h013, 0, 0, 32'h000000AB, busy, busy);
    issue(d, 0, 12'h010, 2, 1, 32'h0, busy, busy);
    issue(d, 0, 12'h013, 0, 1, 32'h0, busy, busy);
    issue(d, 0, 12'h013, 0, 0, 32'h0, busy, busy);
    issue(d, 1, 12'h012, 1, 0, 32'h00008001, busy, busy);
    issue(d, 0, 12'h012, 1, 1, 32'h0, busy, busy);
    issue(d, 0, 12'h010, 1, 0, 32'h0, busy, busy);
    issue(d, 1, 12'h011, 2, 0, 32'h55667788, busy, busy);
    issue(d, 0, 12'h013, 1, 1, 32'h0, busy, busy);
    issue(d, 1, 12'h010, 3, 0, 32'h99999999, busy, busy);
    issue(d, 0, 12'h010, 2, 0, 32'h0, busy, busy);
    idle(d, 2);

    // Randomised traffic in a low window and at the top of the address space.
    ew = -1;
    for (int unsigned t = 0; t < 400; t++) begin
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 63))
                                       : AW'(32'hFC0 + $urandom_range(0, 63));
      sg = 1'($urandom_range(0, 1));
      issue(d, we, a, sz, sg, $urandom(), ew, busy);
      if ($urandom_range(0, 3) == 0) begin
        idle(d, $urandom_range(1, 4));
        ew = -1;
      end else begin
        ew = busy;
      end
    end
    idle(d, 2);

    // Back-to-back stores then loads with req_valid held.
    ew = -1;
    for (int unsigned i = 0; i < 8; i++) begin
      issue(d, 1, AW'(12'h100 + i * 4), 2, 0, $urandom(), ew, busy);
      ew = busy;
    end
    for (int unsigned i = 0; i < 8; i++) begin
      issue(d, 0, AW'(12'h100 + i * 4), 2, 0, 32'h0, ew, busy);
      ew = busy;
    end
    idle(d, 6);

    // Reset while a load is in WAIT (RD_LAT=3 instance only).
    issue(d, 1, 12'h020, 2, 0, 32'hCAFEF00D, -1, busy);
    idle(d, 4);
    if (d == 1) begin
      issue(d, 0, 12'h020, 2, 0, 32'h0, -1, busy);
      q_drop_last(d);
      rst_n[d] = 1'b0;
      req_valid[d] = 1'b0;
      @(negedge clk);
      rst_n[d] = 1'b1;
      check("ready_after_wait_reset", {31'b0, ready_of(d)}, 32'd1);
      idle(d, 6);
    end

    // A store presented during reset must not commit.
    rst_n[d] = 1'b0;
    req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = 12'h020;
    req_size[d] = 2'd2; req_signed[d] = 1'b0; req_wdata[d] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    rst_n[d] = 1'b1;
    req_valid[d] = 1'b0;
    check($sformatf("ready_after_reset%0d", d), {31'b0, ready_of(d)}, 32'd1);
    idle(d, 2);
    issue(d, 0, 12'h020, 2, 0, 32'h0, -1, busy);
    issue(d, 0, 12'h010, 2, 0, 32'h0, busy, busy);
    idle(d, 6);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = '0; req_valid = '0; req_we = '0; req_addr = '0;
    req_size = '0; req_signed = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = '1;
    check("reset_ready0", {31'b0, rdy0}, 32'd1);
    check("reset_ready1", {31'b0, rdy1}, 32'd1);
    for (int unsigned d = 0; d < 2; d++) run_instance(d);
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("pending_rsp0", 32'(q0.size()), 32'd0);
    check("pending_rsp1", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_byte_ctrl.md
DM_BYTE_CTRL -- requirements
Module: dm_byte_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12, byte-address width; memory holds 2^(ADDR_W-2) 32-bit words.
REQ-002 Parameter RD_LAT, default 1, read latency in cycles from accept edge to rsp_valid; legal range 1..4.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  ADDR_W  byte address.
REQ-009 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-011 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 rsp_valid  output  1  one-cycle response pulse.
REQ-013 rsp_rdata  output  32  load result, extended to 32 bits.
REQ-014 rsp_err  output  1  request rejected as misaligned or illegal size; qualified by rsp_valid.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Accept = req_valid & req_ready on a rising edge; request fields sampled only at accept.
REQ-017 Error = size 11, or half with addr[0]=1, or word with addr[1:0]!=00.
REQ-018 Byte lanes little-endian: lane k = word bits [8k+7:8k], lane selected by addr[1:0]; word index = addr[ADDR_W-1:2].
REQ-019 Store, no error: at the accept edge write only addressed lanes (byte: 1 lane; half: lanes 0-1 if addr[1]=0 else 2-3; word: all 4); other lanes unchanged.
REQ-020 Store or any error: IDLE -> RESP at accept; rsp_valid=1 the following cycle; rsp_rdata=0.
REQ-021 Errored request: no memory write; rsp_err=1 with rsp_valid; rsp_err=0 otherwise.
REQ-022 Load, no error: word read and lane-extracted at accept edge into a data register; IDLE -> RESP if RD_LAT=1, else IDLE -> WAIT with latency counter, WAIT -> RESP after RD_LAT-1 cycles; rsp_valid exactly RD_LAT cycles after accept.
REQ-023 Load extension: byte/half zero- or sign-extended per req_signed; word returned unchanged; req_signed ignored for stores and words.
REQ-024 RESP lasts exactly one cycle then -> IDLE; no response backpressure; max throughput one request per RD_LAT+1 cycles.
REQ-025 req_valid while req_ready=0 SHALL be ignored (not queued); requester holds until accepted.
REQ-026 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-027 Address wrap: upper address bits beyond ADDR_W not present; all word indices in range, no out-of-bound case.

Reset
REQ-028 rst_n=0 at a rising edge: state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 from first cycle after reset release.
REQ-029 Memory array SHALL NOT be reset; contents persist across reset.
REQ-030 Reset mid-operation (WAIT or RESP): transaction dropped, no rsp_valid issued; a store already accepted remains committed.
REQ-031 Request presented in same cycle as rst_n=0 SHALL NOT be accepted.

Verification
REQ-032 Word store 0x11223344 @0x010, then word load @0x010 -> rsp_valid after RD_LAT cycles, rsp_rdata=0x11223344, rsp_err=0.
REQ-033 Byte store 0xAB @0x013 over that word, then word load -> 0xAB223344; byte load @0x013 signed -> 0xFFFFFFAB, unsigned -> 0x000000AB.
REQ-034 Half store 0x8001 @0x012, half load @0x012 signed -> 0xFFFF8001; half load @0x010 unsigned -> 0x00003344.
REQ-035 Word store @0x011 and half load @0x013 -> rsp_err=1, rsp_rdata=0, memory word @0x010 unchanged on readback.
REQ-036 RD_LAT=3 build: load accepted, req_valid held high -> req_ready=0 for 3 cycles, rsp_valid on 3rd cycle after accept, next accept cycle after; reset asserted in WAIT -> no rsp_valid, req_ready=1 after release.
REQ-037 Back-to-back stores with req_valid held -> one accept every 2 cycles, rsp_valid pulses one cycle each, no lost or duplicated writes.
